// File: rtl/sd_dat_rx_if.sv
// Bundle of the DAT receive stage's control, serial and result signals.
// The master drives the request/abort and serial line; the slave is the deserializer.
interface sd_dat_rx_if #(
  parameter int N = 8
);
  logic         start_rx;
  logic         abort;
  logic         dat_in;
  logic [N-1:0] parallel;
  logic         word_valid;
  logic         block_done;
  logic         crc_error;
  logic         end_error;
  logic         timeout;
  logic         busy;

  modport master (
    output start_rx, abort, dat_in,
    input  parallel, word_valid, block_done, crc_error, end_error, timeout, busy
  );

  modport slave (
    input  start_rx, abort, dat_in,
    output parallel, word_valid, block_done, crc_error, end_error, timeout, busy
  );
endinterface

// File: rtl/sd_dat_rx_deserializer.sv
// SD DAT-line receiver: waits for a start bit, deserializes a block MSB first,
// then checks the trailing CRC16-CCITT and end bit and reports the result.
module sd_dat_rx_deserializer #(
  parameter int N              = 8,
  parameter int BLOCK_WORDS    = 512,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic     sd_clock,
  input  logic     reset,
  sd_dat_rx_if.slave bus
);
  localparam int DATA_BITS = BLOCK_WORDS * N;
  localparam int CNT_W     = $clog2(DATA_BITS + 18);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WB_W      = $clog2(N);

  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CRC_BIT  = CNT_W'(DATA_BITS + 15);
  localparam logic [TO_W-1:0]  TO_LIMIT      = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_SAT        = '1;
  localparam logic [WB_W-1:0]  LAST_WORD_BIT = WB_W'(N - 1);
  localparam logic [15:0]      CRC_POLY      = 16'h1021;

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, DONE} state_t;

  state_t           state_reg;
  logic [N-2:0]     shift_reg;
  logic [N-1:0]     parallel_reg;
  logic             word_valid_reg;
  logic             block_done_reg;
  logic             crc_error_reg;
  logic             end_error_reg;
  logic             timeout_reg;
  logic [15:0]      crc_reg;
  logic [15:0]      rx_crc_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [WB_W-1:0]  word_bit_reg;
  logic [TO_W-1:0]  to_cnt_reg;

  logic [N-1:0]     word_next;
  logic [15:0]      crc_next;
  logic [TO_W-1:0]  to_cnt_next;
  logic             crc_fb;

  always_comb begin
    word_next   = {shift_reg, bus.dat_in};
    crc_fb      = crc_reg[15] ^ bus.dat_in;
    crc_next    = {crc_reg[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
    // Saturating so a huge TIMEOUT_CYCLES can never wrap back to zero.
    to_cnt_next = (to_cnt_reg == TO_SAT) ? to_cnt_reg : to_cnt_reg + 1'b1;
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      parallel_reg   <= '0;
      word_valid_reg <= 1'b0;
      block_done_reg <= 1'b0;
      crc_error_reg  <= 1'b0;
      end_error_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
      crc_reg        <= '0;
      rx_crc_reg     <= '0;
      bit_cnt_reg    <= '0;
      word_bit_reg   <= '0;
      to_cnt_reg     <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      block_done_reg <= 1'b0;
      if (bus.abort && state_reg != IDLE) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start_rx && !bus.abort) begin
              state_reg     <= WAIT_START;
              crc_error_reg <= 1'b0;
              end_error_reg <= 1'b0;
              timeout_reg   <= 1'b0;
              to_cnt_reg    <= '0;
              crc_reg       <= '0;
              bit_cnt_reg   <= '0;
              word_bit_reg  <= '0;
            end
          end
          WAIT_START: begin
            if (!bus.dat_in) begin
              state_reg <= DATA;
            end else begin
              to_cnt_reg <= to_cnt_next;
              if (to_cnt_next >= TO_LIMIT) begin
                state_reg      <= DONE;
                timeout_reg    <= 1'b1;
                block_done_reg <= 1'b1;
              end
            end
          end
          DATA: begin
            shift_reg   <= word_next[N-2:0];
            crc_reg     <= crc_next;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (word_bit_reg == LAST_WORD_BIT) begin
              parallel_reg   <= word_next;
              word_valid_reg <= 1'b1;
              word_bit_reg   <= '0;
            end else begin
              word_bit_reg <= word_bit_reg + 1'b1;
            end
            if (bit_cnt_reg == LAST_DATA_BIT)
              state_reg <= CRC;
          end
          CRC: begin
            rx_crc_reg  <= {rx_crc_reg[14:0], bus.dat_in};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_CRC_BIT)
              state_reg <= END;
          end
          END: begin
            end_error_reg  <= !bus.dat_in;
            crc_error_reg  <= (rx_crc_reg != crc_reg);
            block_done_reg <= 1'b1;
            state_reg      <= DONE;
          end
          DONE: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.parallel   = parallel_reg;
  assign bus.word_valid = word_valid_reg;
  assign bus.block_done = block_done_reg;
  assign bus.crc_error  = crc_error_reg;
  assign bus.end_error  = end_error_reg;
  assign bus.timeout    = timeout_reg;
  assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_sd_dat_rx_deserializer.sv
// Randomized scoreboard bench for the DAT receive deserializer (N=8, 4-word blocks,
// 20-cycle start timeout); expectations come from a byte-wise CRC model and cycle arithmetic.
module tb_sd_dat_rx_deserializer;
  localparam int N  = 8;
  localparam int BW = 4;
  localparam int TO = 20;
  localparam int M_NORMAL = 0;
  localparam int M_ABORT  = 1;
  localparam int M_RESET  = 2;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    bit         crc_e;
    bit         end_e;
    bit         to_e;
    int         cyc;
  } exp_t;

  logic sd_clock = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   tests    = 0;
  int   fails    = 0;
  exp_t q[$];

  sd_dat_rx_if #(.N(N)) bus ();

  sd_dat_rx_deserializer #(.N(N), .BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TO)) dut (
    .sd_clock(sd_clock),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 sd_clock = ~sd_clock;
  always @(posedge sd_clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC16-CCITT (poly 0x1021, init 0) processed a whole byte at a time.
  function automatic logic [15:0] crc16_model(input logic [7:0] d [4]);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < BW; i++) begin
      c = c ^ {d[i], 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge sd_clock) begin
    exp_t e;
    if (bus.word_valid || bus.block_done) begin
      check("event_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (bus.word_valid) begin
          $display("[TB] word 0x%02h at cycle %0d", bus.parallel, cyc);
          check("word_kind", int'(e.is_done), 0);
          check("word_data", bus.parallel, e.data);
          check("word_cycle", cyc, e.cyc);
        end else begin
          $display("[TB] block_done crc_err=%0b end_err=%0b timeout=%0b at cycle %0d",
                   bus.crc_error, bus.end_error, bus.timeout, cyc);
          check("done_kind", int'(e.is_done), 1);
          check("done_crc_error", bus.crc_error, e.crc_e);
          check("done_end_error", bus.end_error, e.end_e);
          check("done_timeout", bus.timeout, e.to_e);
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    bus.dat_in = b;
    @(posedge sd_clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_parallel"}, bus.parallel, 0);
    check({tag, "_word_valid"}, bus.word_valid, 0);
    check({tag, "_block_done"}, bus.block_done, 0);
    check({tag, "_crc_error"}, bus.crc_error, 0);
    check({tag, "_end_error"}, bus.end_error, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic send_block(input logic [7:0] d [4], input bit flip_crc, input bit end_bit,
                            input int gap, input int mode, input bit poke_start);
    logic [15:0] crc;
    int          t0;
    exp_t        e;
    bus.dat_in   = 1'b1;
    bus.start_rx = 1'b1;
    @(posedge sd_clock);
    #1;
    bus.start_rx = 1'b0;
    check("armed_busy", bus.busy, 1);
    check("armed_flags_clear", {bus.crc_error, bus.end_error, bus.timeout}, 0);
    repeat (gap) drive_bit(1'b1);
    drive_bit(1'b0);
    t0 = cyc;
    for (int w = 0; w < BW; w++) begin
      for (int b = 7; b >= 0; b--) begin
        if (poke_start && w == 1 && b == 4) bus.start_rx = 1'b1;
        drive_bit(d[w][b]);
        bus.start_rx = 1'b0;
      end
      e = '{is_done: 1'b0, data: d[w], crc_e: 1'b0, end_e: 1'b0, to_e: 1'b0, cyc: t0 + (w + 1) * N};
      q.push_back(e);
      if (mode == M_ABORT && w == 1) begin
        bus.abort = 1'b1;
        drive_bit(d[2][7]);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        repeat (4) drive_bit(1'b1);
        return;
      end
    end
    crc = crc16_model(d);
    if (flip_crc) crc[5] = ~crc[5];
    for (int b = 15; b >= 0; b--) begin
      if (mode == M_RESET && b == 10) begin
        reset = 1'b1;
        @(posedge sd_clock);
        #1;
        check_all_zero("reset_in_crc");
        reset      = 1'b0;
        bus.dat_in = 1'b1;
        repeat (3) drive_bit(1'b1);
        return;
      end
      drive_bit(crc[b]);
    end
    drive_bit(end_bit);
    e = '{is_done: 1'b1, data: 8'h00, crc_e: flip_crc, end_e: !end_bit, to_e: 1'b0,
          cyc: t0 + BW * N + 17};
    q.push_back(e);
    repeat (3) drive_bit(1'b1);
  endtask

  task automatic run_timeout();
    int   e0;
    exp_t e;
    bus.dat_in   = 1'b1;
    bus.start_rx = 1'b1;
    @(posedge sd_clock);
    #1;
    bus.start_rx = 1'b0;
    e0 = cyc;
    e = '{is_done: 1'b1, data: 8'h00, crc_e: 1'b0, end_e: 1'b0, to_e: 1'b1, cyc: e0 + TO};
    q.push_back(e);
    repeat (TO + 5) drive_bit(1'b1);
    check("timeout_busy_after", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] blk [4];
    bus.start_rx = 1'b0;
    bus.abort    = 1'b0;
    bus.dat_in   = 1'b1;
    repeat (3) @(posedge sd_clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) drive_bit(1'b1);

    blk = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    send_block(blk, 1'b0, 1'b1, 3, M_NORMAL, 1'b0);
    send_block(blk, 1'b1, 1'b1, 3, M_NORMAL, 1'b0);
    send_block(blk, 1'b0, 1'b0, 2, M_NORMAL, 1'b0);
    send_block(blk, 1'b0, 1'b1, 1, M_NORMAL, 1'b0);
    run_timeout();
    send_block(blk, 1'b0, 1'b1, 3, M_ABORT, 1'b0);
    send_block(blk, 1'b0, 1'b1, 0, M_NORMAL, 1'b0);
    send_block(blk, 1'b0, 1'b1, 2, M_RESET, 1'b0);
    send_block(blk, 1'b0, 1'b1, 2, M_NORMAL, 1'b0);
    send_block(blk, 1'b0, 1'b1, 4, M_NORMAL, 1'b1);

    // Abort alone, and abort together with start_rx, must leave an idle receiver idle.
    bus.abort = 1'b1;
    drive_bit(1'b1);
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 0);
    bus.abort    = 1'b1;
    bus.start_rx = 1'b1;
    drive_bit(1'b1);
    bus.abort    = 1'b0;
    bus.start_rx = 1'b0;
    check("start_abort_busy", bus.busy, 0);

    for (int i = 0; i < 20; i++) begin
      for (int w = 0; w < BW; w++) blk[w] = 8'($urandom_range(0, 255));
      send_block(blk, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 10), M_NORMAL, $urandom_range(0, 4) == 0);
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge sd_clock);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_dat_rx_deserializer.md
Name: sd_dat_rx_deserializer

Overview:
Receive-side DAT-line stage for the SD host. It samples the single serial DAT line and waits for a start bit. It then deserializes a fixed-size data block into N-bit words, MSB first, and checks the trailing CRC16 and end bit. It reports the block result to the data-path controller and sits on the serial side opposite the transmit parallel-to-serial stage.

Parameters:
N, 8, output word width in bits (>=2)
BLOCK_WORDS, 512, words per data block
TIMEOUT_CYCLES, 65535, sd_clock cycles allowed in WAIT_START before timeout (>=1)

Ports:
sd_clock  input  1  DAT sampling clock; all logic on posedge
reset  input  1  synchronous, active-high
start_rx  input  1  one-cycle request to arm reception; ignored unless idle
abort  input  1  synchronous abort; returns to IDLE
dat_in  input  1  serial DAT line (idle high)
parallel  output  N  last completed word, MSB = first received bit
word_valid  output  1  one-cycle strobe: parallel holds a new word
block_done  output  1  one-cycle strobe: block finished or timed out
crc_error  output  1  received CRC16 != computed; valid from block_done until next start_rx
end_error  output  1  end bit sampled 0; same validity as crc_error
timeout  output  1  no start bit within TIMEOUT_CYCLES; same validity
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: reset is synchronous, active-high; clock is sd_clock.
  - Every output is 0. parallel = 0. FSM = IDLE. All counters and the CRC register are 0.
  - Reset overrides start_rx and abort, including mid-block.
- States: IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE: start_rx=1 -> WAIT_START. Entering from IDLE clears crc_error, end_error, timeout, the timeout counter and CRC (init 0x0000).
- WAIT_START:
  - dat_in sampled 0 -> DATA; the next posedge samples data bit 0.
  - Otherwise the timeout counter increments.
  - When it reaches TIMEOUT_CYCLES, go to DONE with timeout=1.
- DATA:
  - Shift dat_in into a word shift register every cycle, MSB first.
  - Feed each bit into the CRC16-CCITT register: x^16+x^12+x^5+1, init 0, MSB-first, no reflection, no final XOR.
  - On the edge sampling the word's bit N-1: load parallel and set word_valid=1 for exactly the following cycle.
  - After BLOCK_WORDS*N bits -> CRC.
- CRC: sample 16 bits MSB first into the received-CRC register. After the 16th bit -> END.
- END: sample one bit; if 0, set end_error=1. Compare received CRC vs computed; mismatch sets crc_error=1. -> DONE.
- DONE: block_done=1 for exactly this one cycle; error flags already valid. Next state IDLE.
- Latency:
  - Start bit sampled at edge T0.
  - Word k (k from 0) is valid in the cycle after edge T0+(k+1)*N.
  - block_done is high in the cycle after edge T0+BLOCK_WORDS*N+17.
- start_rx while busy: ignored, no effect on counters or flags.
- abort=1 in any non-IDLE state:
  - Next state IDLE; no word_valid, no block_done.
  - Error flags are left unchanged.
  - abort takes precedence over start_rx and over the state's normal transition.
- abort in IDLE: no effect.
- start_rx and abort in the same cycle from IDLE: abort wins; stay IDLE.
- dat_in glitches low outside WAIT_START: treated as data, no resync.
- Counters:
  - Bit counter is wide enough for BLOCK_WORDS*N+17.
  - The timeout counter saturates and never wraps.
- parallel holds its last value between words and after DONE.

Test Plan:
- Bench setup: N=8, BLOCK_WORDS=4, TIMEOUT_CYCLES=20. Golden CRC16 comes from the bench model.
- Nominal block: start_rx, 3 idle-high cycles, start bit 0, bytes 0xA5,0x3C,0xFF,0x00, golden CRC, end bit 1 -> four word_valid pulses spaced 8 cycles apart with parallel=0xA5,0x3C,0xFF,0x00. block_done arrives 17 cycles after the last word's edge, with crc_error=0, end_error=0, timeout=0.
- CRC corruption: same block with CRC bit 5 flipped -> all four words delivered, block_done=1, crc_error=1, end_error=0.
- Bad end bit: golden CRC, end bit 0 -> block_done, end_error=1, crc_error=0. A new start_rx clears end_error.
- Timeout: start_rx with dat_in held 1 -> block_done with timeout=1 exactly 20 cycles after entering WAIT_START; no word_valid; busy=0 afterwards.
- Abort/reset mid-block, covering:
  - abort after the 2nd word -> busy=0 next cycle, no block_done; a subsequent nominal block passes.
  - reset asserted in CRC state -> all outputs 0 on the next cycle.
  - start_rx pulsed during DATA -> ignored; the block completes normally.
